// File: rtl/enc_par_engine.sv
// Streaming Reed-Solomon parity engine: absorbs message beats through a
// SYM_NUM-lane LFSR divider and emits the PAR_LEN parity symbols per codeword.

package enc_par_pkg;
    localparam logic [7:0] EGF_PRI_POL = 8'h1d;

    function automatic logic [7:0] gf_mul8(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ EGF_PRI_POL) : (x << 1);
        end
        return r;
    endfunction

    // Product of (x + alpha^i) for i = 0..15, monic term dropped.
    function automatic logic [127:0] rs_gen_pol();
        logic [16:0][7:0] g;
        logic [7:0]       a;
        logic [127:0]     v;
        g    = '0;
        g[0] = 8'h01;
        a    = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j > 0; j--)
                g[j] = g[j-1] ^ gf_mul8(g[j], a);
            g[0] = gf_mul8(g[0], a);
            a = gf_mul8(a, 8'h02);
        end
        v = '0;
        for (int j = 0; j < 16; j++)
            v[j*8 +: 8] = g[j];
        return v;
    endfunction

    localparam logic [127:0] RS_GEN_POL = rs_gen_pol();
endpackage

module enc_par_engine
    import enc_par_pkg::*;
#(
    parameter int EGF_ORDER   = 8,
    parameter logic [EGF_ORDER-1:0] PRI_POL = EGF_PRI_POL,
    parameter int SYM_NUM     = 4,
    parameter int PAR_LEN     = 16,
    parameter int MES_LEN_MAX = 239,
    parameter logic [PAR_LEN-1:0][EGF_ORDER-1:0] GEN_POL = RS_GEN_POL,
    localparam int LW = $clog2(MES_LEN_MAX + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [LW-1:0]                     cfg_len,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SYM_NUM-1:0][EGF_ORDER-1:0] in_data,
    output logic                              par_valid,
    input  logic                              par_ready,
    output logic [SYM_NUM-1:0][EGF_ORDER-1:0] par_data,
    output logic                              par_last,
    output logic                              cfg_err,
    output logic                              busy
);

    localparam int BPL  = PAR_LEN / SYM_NUM;
    localparam int BMAX = (MES_LEN_MAX + SYM_NUM - 1) / SYM_NUM;
    localparam int BLW  = $clog2(BMAX + 1);
    localparam int KW   = (BPL > 1) ? $clog2(BPL) : 1;

    typedef enum logic [1:0] {IDLE, ABSORB, EMIT} state_t;
    typedef logic [PAR_LEN-1:0][EGF_ORDER-1:0] par_t;
    typedef logic [SYM_NUM-1:0][EGF_ORDER-1:0] beat_t;

    state_t         state, state_nx;
    par_t           par_q, par_nx, par_shift;
    beat_t          par_data_q;
    logic [BLW-1:0] beats_left;
    logic [KW-1:0]  beat_k;
    logic           par_last_q, cfg_err_q;
    logic           in_hs, par_hs, len_ok, last_beat;
    logic [LW:0]    nbeats;
    logic [LW-1:0]  rem;
    logic [SYM_NUM-1:0]   lane_en;
    logic [EGF_ORDER-1:0] fb;

    function automatic logic [EGF_ORDER-1:0] gf_mul(
        input logic [EGF_ORDER-1:0] a,
        input logic [EGF_ORDER-1:0] b
    );
        logic [EGF_ORDER-1:0] r;
        logic [EGF_ORDER-1:0] x;
        r = '0;
        x = a;
        for (int k = 0; k < EGF_ORDER; k++) begin
            if (b[k]) r = r ^ x;
            x = x[EGF_ORDER-1] ? ((x << 1) ^ PRI_POL) : (x << 1);
        end
        return r;
    endfunction

    assign in_ready  = rst_n && (state != EMIT);
    assign in_hs     = in_valid && in_ready;
    assign par_hs    = (state == EMIT) && par_ready;
    assign len_ok    = (cfg_len != '0) && (cfg_len <= LW'(MES_LEN_MAX));
    assign nbeats    = ({1'b0, cfg_len} + (LW+1)'(SYM_NUM - 1))
                       / (LW+1)'(SYM_NUM);
    assign rem       = cfg_len % LW'(SYM_NUM);
    assign last_beat = (beat_k == KW'(BPL - 1));
    assign par_shift = par_q << (SYM_NUM * EGF_ORDER);

    // A short first beat carries its symbols in the low lanes only.
    always_comb begin
        lane_en = '1;
        if (state == IDLE && rem != '0) begin
            for (int i = 0; i < SYM_NUM; i++)
                lane_en[i] = (LW'(i) < rem);
        end
    end

    always_comb begin
        par_nx = (state == IDLE) ? '0 : par_q;
        fb     = '0;
        for (int i = SYM_NUM - 1; i >= 0; i--) begin
            if (lane_en[i]) begin
                fb = in_data[i] ^ par_nx[PAR_LEN-1];
                for (int j = PAR_LEN - 1; j > 0; j--)
                    par_nx[j] = par_nx[j-1] ^ gf_mul(fb, GEN_POL[j]);
                par_nx[0] = gf_mul(fb, GEN_POL[0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_hs && len_ok)
                    state_nx = (nbeats == (LW+1)'(1)) ? EMIT : ABSORB;
            end
            ABSORB: begin
                if (in_hs && beats_left == BLW'(1))
                    state_nx = EMIT;
            end
            EMIT: begin
                if (par_hs && last_beat)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q      <= '0;
            par_data_q <= '0;
            beats_left <= '0;
            beat_k     <= '0;
            par_last_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= (state == IDLE) && in_hs && !len_ok;
            unique case (state)
                IDLE: begin
                    if (in_hs && len_ok) begin
                        par_q      <= par_nx;
                        beats_left <= BLW'(nbeats - 1'b1);
                        beat_k     <= '0;
                        if (state_nx == EMIT) begin
                            par_data_q <= par_nx[PAR_LEN-1 -: SYM_NUM];
                            par_last_q <= (BPL == 1);
                        end
                    end
                end
                ABSORB: begin
                    if (in_hs) begin
                        par_q      <= par_nx;
                        beats_left <= beats_left - BLW'(1);
                        if (beats_left == BLW'(1)) begin
                            par_data_q <= par_nx[PAR_LEN-1 -: SYM_NUM];
                            par_last_q <= (BPL == 1);
                        end
                    end
                end
                EMIT: begin
                    if (par_hs) begin
                        if (last_beat) begin
                            par_q      <= '0;
                            par_data_q <= '0;
                            par_last_q <= 1'b0;
                            beat_k     <= '0;
                        end else begin
                            par_q      <= par_shift;
                            par_data_q <= par_shift[PAR_LEN-1 -: SYM_NUM];
                            par_last_q <= (beat_k == KW'(BPL - 2));
                            beat_k     <= beat_k + KW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign par_valid = (state == EMIT);
    assign par_data  = par_data_q;
    assign par_last  = par_last_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_enc_par_engine.sv
// Directed self-checking bench for enc_par_engine (RS(255,239), 4 lanes),
// with a log/antilog GF(256) reference encoder.

module tb_enc_par_engine;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      cfg_len;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] in_data;
    logic            par_valid;
    logic            par_ready;
    logic [3:0][7:0] par_data;
    logic            par_last;
    logic            cfg_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]   gexp [0:254];
    int           glog [0:255];
    logic [7:0]   msg  [0:238];
    logic [7:0]   exp_p [0:15];
    logic [31:0]  rx   [0:3];
    logic [127:0] gp_v;

    always #5 clk = ~clk;

    enc_par_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .par_data  (par_data),
        .par_last  (par_last),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a,
                                       input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic model(input int len);
        logic [7:0] fb;
        for (int j = 0; j < 16; j++) exp_p[j] = 8'h00;
        for (int n = 0; n < len; n++) begin
            fb = msg[n] ^ exp_p[15];
            for (int j = 15; j > 0; j--)
                exp_p[j] = exp_p[j-1] ^ mul(fb, gp_v[j*8 +: 8]);
            exp_p[0] = mul(fb, gp_v[7:0]);
        end
    endtask

    task automatic rand_msg(input int len);
        for (int n = 0; n < len; n++) msg[n] = 8'($urandom);
    endtask

    // Called at a negedge; returns at the negedge after the last handshake.
    task automatic feed(input int len, input int max_gap, input int limit);
        int nb, r, idx, n, gap;
        logic [3:0][7:0] beat;
        nb  = (len + 3) / 4;
        r   = len % 4;
        idx = 0;
        if (limit > 0 && limit < nb) nb = limit;
        for (int b = 0; b < nb; b++) begin
            gap = int'($urandom_range(0, max_gap));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 32'($urandom);
                @(negedge clk);
            end
            n = (b == 0 && r != 0) ? r : 4;
            beat = 32'($urandom);
            for (int k = 0; k < n; k++) beat[n-1-k] = msg[idx+k];
            idx += n;
            cfg_len  = (b == 0) ? 8'(len) : 8'($urandom_range(240, 255));
            in_valid = 1'b1;
            in_data  = beat;
            check("in_ready_absorb", in_ready, 1);
            check("par_valid_absorb", par_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int max_stall);
        logic [31:0] hold, expv;
        int st;
        for (int k = 0; k < 4; k++) begin
            check("par_valid", par_valid, 1);
            expv = {exp_p[15-4*k], exp_p[14-4*k],
                    exp_p[13-4*k], exp_p[12-4*k]};
            if (max_stall > 0) begin
                st = int'($urandom_range(0, max_stall));
                par_ready = 1'b0;
                hold = par_data;
                for (int s = 0; s < st; s++) begin
                    @(negedge clk);
                    check("stall_stable", par_data, hold);
                    check("stall_valid", par_valid, 1);
                end
            end
            check("par_data", par_data, expv);
            check("par_last", par_last, (k == 3));
            rx[k] = par_data;
            par_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (max_stall > 0) par_ready = 1'b0;
        end
        check("idle_valid", par_valid, 0);
        check("idle_ready", in_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic bad_cfg(input logic [7:0] len);
        cfg_len  = len;
        in_valid = 1'b1;
        in_data  = 32'($urandom);
        check("bad_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("bad_par_valid", par_valid, 0);
        check("bad_in_ready2", in_ready, 1);
        check("bad_busy", busy, 0);
        @(negedge clk);
        check("cfg_err_clear", cfg_err, 0);
        check("bad_par_valid2", par_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        gp_v = enc_par_pkg::RS_GEN_POL;
        build_tables();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        par_ready = 1'b0;
        cfg_len   = 8'd0;
        in_data   = '0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_par_valid", par_valid, 0);
        check("rst_par_data", par_data, 0);
        check("rst_par_last", par_last, 0);
        check("rst_cfg_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        for (int n = 0; n < 239; n++) msg[n] = 8'h00;
        model(239);
        par_ready = 1'b1;
        feed(239, 0, 0);
        collect(0);
        check("zero_beat0", rx[0], 0);
        check("zero_beat3", rx[3], 0);

        msg[0] = 8'h01;
        model(1);
        feed(1, 0, 0);
        collect(0);
        check("gen_hi", rx[0], gp_v[127:96]);
        check("gen_lo", rx[3], gp_v[31:0]);

        rand_msg(239);
        model(239);
        par_ready = 1'b0;
        feed(239, 5, 0);
        collect(5);

        bad_cfg(8'd240);
        bad_cfg(8'd0);
        rand_msg(5);
        model(5);
        feed(5, 1, 0);
        collect(2);

        rand_msg(239);
        feed(239, 2, 30);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", par_valid, 0);
        check("mid_rst_data", par_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", par_valid, 0);
        check("post_rst_ready", in_ready, 1);
        rand_msg(239);
        model(239);
        feed(239, 1, 0);
        collect(3);

        par_ready = 1'b1;
        rand_msg(4);
        model(4);
        feed(4, 0, 0);
        collect(0);
        rand_msg(5);
        model(5);
        feed(5, 0, 0);
        collect(0);
        rand_msg(8);
        model(8);
        feed(8, 0, 0);
        collect(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
